// File: rtl/seq_det_pkg.sv
// ============================================================================
// Module   : seq_det_pkg
// Brief    : Shared constants, state decode type and helper function for the
//            parametrised serial-pattern detector.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_det_pkg;

   // Largest supported pattern length
   localparam int LEN_MAX = 32;

   // Decoded detector state, derived from the fill counter
   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      FILLING = 2'd1,
      PRIMED  = 2'd2
   } det_state_e;

   // Width of the fill counter for a given pattern length
   function automatic int fill_w(input int len);
      return $clog2(len);
   endfunction

endpackage

`default_nettype wire

// File: rtl/seq_det_if.sv
// ============================================================================
// Module   : seq_det_if
// Brief    : Serial-stream, mode and pattern-load signals of the detector.
//            SEQ_DET_COUNT_EN adds the match_count return signal.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seq_det_if
   import seq_det_pkg::*;
#(
   parameter int LEN   = 4,
   parameter int CNT_W = 8
);
   logic             x;
   logic             x_valid;
   logic             overlap;
   logic             pat_load;
   logic [LEN-1:0]   pat_in;
   logic             z;
`ifdef SEQ_DET_COUNT_EN
   logic [CNT_W-1:0] match_count;

   modport master (output x, x_valid, overlap, pat_load, pat_in,
                   input  z, match_count);
   modport slave  (input  x, x_valid, overlap, pat_load, pat_in,
                   output z, match_count);
`else
   modport master (output x, x_valid, overlap, pat_load, pat_in,
                   input  z);
   modport slave  (input  x, x_valid, overlap, pat_load, pat_in,
                   output z);
`endif
endinterface

`default_nettype wire

// File: rtl/seq_det_sat_counter.sv
// ============================================================================
// Module   : seq_det_sat_counter
// Brief    : Saturating up-counter with synchronous clear; holds at all-ones.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_det_sat_counter #(
   parameter int W = 8
) (
   input  wire logic         clk,
   input  wire logic         rst,
   input  wire logic         i_inc,
   input  wire logic         i_clr,
   output logic [W-1:0]      o_count
);

   logic [W-1:0] r_count;

   // Count up on i_inc until all-ones; clear wins over increment
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_inc && (r_count != {W{1'b1}})) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/seq_detector_param.sv
// ============================================================================
// Module   : seq_detector_param
// Brief    : Mealy serial-pattern detector with runtime-loadable pattern,
//            overlapping / non-overlapping mode and input-valid qualification.
//            Define SEQ_DET_COUNT_EN to add a saturating match counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_detector_param
   import seq_det_pkg::*;
#(
   parameter int             LEN         = 4,
   parameter logic [LEN-1:0] RST_PATTERN = LEN'(4'b1010),
   parameter int             CNT_W       = 8
) (
   input  wire logic clk,
   input  wire logic rst,
   seq_det_if.slave  bus
);

   localparam int                    c_FILL_W    = fill_w(LEN);
   localparam logic [c_FILL_W-1:0]   c_FILL_LAST = c_FILL_W'(LEN - 1);

   logic [LEN-1:0]      r_pat;
   logic [LEN-2:0]      r_hist;
   logic [c_FILL_W-1:0] r_fill;

   logic [LEN-1:0]      w_pat_next;
   logic [LEN-2:0]      w_hist_next;
   logic [c_FILL_W-1:0] w_fill_next;
   logic [LEN-1:0]      w_window;
   logic                w_accept;
   logic                w_hit;
   det_state_e          w_state;

   // State register: pattern, bit history and fill level
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pat  <= RST_PATTERN;
         r_hist <= '0;
         r_fill <= '0;
      end else begin
         r_pat  <= w_pat_next;
         r_hist <= w_hist_next;
         r_fill <= w_fill_next;
      end
   end

   // Next state: load flushes history, accepted bits shift in, a
   // non-overlapped match restarts from empty
   always_comb begin
      w_pat_next  = r_pat;
      w_hist_next = r_hist;
      w_fill_next = r_fill;
      if (bus.pat_load) begin
         w_pat_next  = bus.pat_in;
         w_fill_next = '0;
      end else if (w_accept) begin
         w_hist_next = w_window[LEN-2:0];
         if (w_hit && !bus.overlap) begin
            w_fill_next = '0;
         end else if (r_fill != c_FILL_LAST) begin
            w_fill_next = r_fill + 1'b1;
         end
      end
   end

   // Outputs: state decode and same-cycle match flag (uses only the
   // registered pattern, so pat_in never reaches z combinationally)
   always_comb begin
      w_window = {r_hist, bus.x};
      w_accept = bus.x_valid && !bus.pat_load;
      if (r_fill == '0) begin
         w_state = EMPTY;
      end else if (r_fill == c_FILL_LAST) begin
         w_state = PRIMED;
      end else begin
         w_state = FILLING;
      end
      w_hit = w_accept && (w_state == PRIMED) && (w_window == r_pat);
   end

   assign bus.z = w_hit;

`ifdef SEQ_DET_COUNT_EN
   logic [CNT_W-1:0] w_count;

   seq_det_sat_counter #(
      .W (CNT_W)
   ) u_sat_counter (
      .clk     (clk),
      .rst     (rst),
      .i_inc   (w_hit),
      .i_clr   (bus.pat_load),
      .o_count (w_count)
   );

   assign bus.match_count = w_count;
`endif

endmodule

`default_nettype wire
